mux_arbitro_rr: RTL and testbench

MUX_ARBITRO_RR -- requirements
Module: mux_arbitro_rr

---
 rtl/mux_arbitro_rr.sv | 130 +++++++++++++
 tb/tb_mux_arbitro_rr.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbitro_rr.sv
// Two-input FIFO front end feeding a round-robin arbitrated output register.
// Each source keeps its own order. The output stage stalls whenever the downstream side back-pressures.

module mux_arbitro_rr_fifo #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              nempty,
  output logic              ovf,
  output logic [DATA_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [AW:0]       r_cnt;
  logic              w_wr;

  // full and nempty come from registered count only, so push/pop never loop back into them
  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign nempty = (r_cnt != '0);
  assign w_wr   = push & ~full;
  assign ovf    = push & full;
  assign head   = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !reset) r_mem[r_wr] <= data_in;
  end
endmodule

module mux_arbitro_rr #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push0,
  input  logic              push1,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  output logic              full0,
  output logic              full1,
  input  logic              ready_out,
  output logic              validout,
  output logic [DATA_W-1:0] dataout,
  output logic              selector,
  output logic              err_ovf
);
  typedef enum logic [1:0] {IDLE, SEL0, SEL1} state_t;

  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0]             w_push, w_pop, w_full, w_ne, w_ovf;
  logic [NUM_SRC-1:0][DATA_W-1:0] w_din, w_head;
  logic                           w_load, w_gnt_vld, w_gnt;

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic              r_sel, r_last, r_err;

  assign w_push = {push1, push0};
  assign w_din  = {data_in1, data_in0};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    mux_arbitro_rr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (w_push[g]),
      .pop    (w_pop[g]),
      .data_in(w_din[g]),
      .full   (w_full[g]),
      .nempty (w_ne[g]),
      .ovf    (w_ovf[g]),
      .head   (w_head[g])
    );
  end

  // Under contention the source not granted last wins; otherwise whichever is non-empty
  assign w_load    = (r_state == IDLE) | ready_out;
  assign w_gnt_vld = w_load & (|w_ne);
  assign w_gnt     = (&w_ne) ? ~r_last : w_ne[1];
  assign w_pop     = w_gnt_vld ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      if (|w_ovf) r_err <= 1'b1;
      if (w_load) begin
        if (w_gnt_vld) begin
          r_state <= w_gnt ? SEL1 : SEL0;
          r_data  <= w_head[w_gnt];
          r_sel   <= w_gnt;
          r_last  <= w_gnt;
        end else begin
          r_state <= IDLE;
        end
      end
    end
  end

  assign validout = (r_state != IDLE);
  assign dataout  = r_data;
  assign selector = r_sel;
  assign err_ovf  = r_err;
  assign full0    = w_full[0];
  assign full1    = w_full[1];
endmodule

// File: tb/tb_mux_arbitro_rr.sv
// Directed bench for mux_arbitro_rr: reset, latency, round-robin order, overflow, stall, reset mid-flight.
module tb_mux_arbitro_rr;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push0 = 1'b0, push1 = 1'b0;
  logic [1:0] data_in0 = '0, data_in1 = '0;
  logic       full0, full1;
  logic       ready_out = 1'b0;
  logic       validout;
  logic [1:0] dataout;
  logic       selector;
  logic       err_ovf;
  int         n_tests = 0;
  int         n_fail  = 0;

  mux_arbitro_rr #(.DATA_W(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .push0(push0), .push1(push1),
    .data_in0(data_in0), .data_in1(data_in1), .full0(full0), .full1(full1),
    .ready_out(ready_out), .validout(validout), .dataout(dataout),
    .selector(selector), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push0 = 0; push1 = 0; ready_out = 0; reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if ({validout, dataout, selector} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_out: got %b want 0000", {validout, dataout, selector}); end
    n_tests++; if ({full0, full1, err_ovf} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags: got %b want 000", {full0, full1, err_ovf}); end
  endtask

  task automatic test_latency();
    do_reset();
    ready_out = 1; push0 = 1; data_in0 = 2'b10;
    tick();
    push0 = 0;
    n_tests++; if (validout !== 1'b0) begin n_fail++;
      $display("FAIL lat_same_cycle: got valid=%b want 0", validout); end
    tick();
    n_tests++; if ({validout, dataout, selector} !== 4'b1100) begin n_fail++;
      $display("FAIL lat_word: got %b want 1100", {validout, dataout, selector}); end
    tick();
    n_tests++; if (validout !== 1'b0) begin n_fail++;
      $display("FAIL lat_drain: got valid=%b want 0", validout); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_d [4];
    logic       exp_s [4];
    exp_d = '{2'b01, 2'b11, 2'b10, 2'b00};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    push0 = 1; data_in0 = 2'b01; push1 = 1; data_in1 = 2'b11;
    tick();
    data_in0 = 2'b10; data_in1 = 2'b00;
    tick();
    push0 = 0; push1 = 0; ready_out = 1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if ({validout, dataout, selector} !== {1'b1, exp_d[i], exp_s[i]}) begin n_fail++;
        $display("FAIL rr_seq[%0d]: got %b want %b", i, {validout, dataout, selector}, {1'b1, exp_d[i], exp_s[i]}); end
      tick();
    end
    n_tests++; if (validout !== 1'b0) begin n_fail++;
      $display("FAIL rr_end: got valid=%b want 0", validout); end
  endtask

  task automatic test_overflow();
    logic [1:0] d [5];
    d = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    do_reset();
    push1 = 1; data_in1 = 2'b11;
    tick();
    push1 = 0;
    tick();
    n_tests++; if ({validout, dataout, selector} !== 4'b1111) begin n_fail++;
      $display("FAIL ovf_hold: got %b want 1111", {validout, dataout, selector}); end
    for (int i = 0; i < 5; i++) begin
      push0 = 1; data_in0 = d[i];
      tick();
      if (i == 2) begin
        n_tests++; if (full0 !== 1'b0) begin n_fail++;
          $display("FAIL ovf_full_early: got %b want 0", full0); end
      end
      if (i == 3) begin
        n_tests++; if ({full0, err_ovf} !== 2'b10) begin n_fail++;
          $display("FAIL ovf_full4: got full/err=%b want 10", {full0, err_ovf}); end
      end
    end
    push0 = 0;
    n_tests++; if ({full0, err_ovf} !== 2'b11) begin n_fail++;
      $display("FAIL ovf_drop: got full/err=%b want 11", {full0, err_ovf}); end
    ready_out = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if ({validout, dataout, selector, err_ovf} !== {1'b1, d[i], 1'b0, 1'b1}) begin n_fail++;
        $display("FAIL ovf_drain[%0d]: got %b want %b", i, {validout, dataout, selector, err_ovf}, {1'b1, d[i], 1'b0, 1'b1}); end
    end
    tick();
    n_tests++; if ({validout, err_ovf} !== 2'b01) begin n_fail++;
      $display("FAIL ovf_end: got valid/err=%b want 01", {validout, err_ovf}); end
  endtask

  task automatic test_stall();
    do_reset();
    push0 = 1; data_in0 = 2'b11;
    tick();
    push0 = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if ({validout, dataout, selector} !== 4'b1110) begin n_fail++;
        $display("FAIL stall[%0d]: got %b want 1110", i, {validout, dataout, selector}); end
    end
    ready_out = 1;
    tick();
    n_tests++; if (validout !== 1'b0) begin n_fail++;
      $display("FAIL stall_xfer: got valid=%b want 0", validout); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    push0 = 1; push1 = 1; data_in0 = 2'b01; data_in1 = 2'b10;
    repeat (5) tick();
    push0 = 0; push1 = 0;
    n_tests++; if ({validout, full0, full1, err_ovf} !== 4'b1111) begin n_fail++;
      $display("FAIL rst_pre: got %b want 1111", {validout, full0, full1, err_ovf}); end
    reset = 1; ready_out = 1;
    tick();
    reset = 0;
    n_tests++; if ({validout, full0, full1, err_ovf} !== 4'b0000) begin n_fail++;
      $display("FAIL rst_mid: got %b want 0000", {validout, full0, full1, err_ovf}); end
    push0 = 1; push1 = 1; data_in0 = 2'b01; data_in1 = 2'b10;
    tick();
    push0 = 0; push1 = 0;
    tick();
    n_tests++; if ({validout, dataout, selector} !== 4'b1010) begin n_fail++;
      $display("FAIL rst_first_gnt: got %b want 1010", {validout, dataout, selector}); end
    tick();
    n_tests++; if ({validout, dataout, selector} !== 4'b1101) begin n_fail++;
      $display("FAIL rst_second_gnt: got %b want 1101", {validout, dataout, selector}); end
  endtask

  task automatic test_full_push_pop();
    logic [1:0] w [7];
    logic [1:0] exp_tail [4];
    w = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
    exp_tail = '{2'd2, 2'd3, 2'd0, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push1 = 1; data_in1 = w[i];
      tick();
    end
    n_tests++; if ({full1, err_ovf, validout, dataout} !== {3'b101, w[0]}) begin n_fail++;
      $display("FAIL fpp_setup: got %b want %b", {full1, err_ovf, validout, dataout}, {3'b101, w[0]}); end
    data_in1 = w[5]; ready_out = 1;
    tick();
    push1 = 0; ready_out = 0;
    n_tests++; if ({full1, err_ovf, dataout, selector} !== {2'b01, w[1], 1'b1}) begin n_fail++;
      $display("FAIL fpp_same_cycle: got %b want %b", {full1, err_ovf, dataout, selector}, {2'b01, w[1], 1'b1}); end
    push1 = 1; data_in1 = w[6];
    tick();
    push1 = 0;
    n_tests++; if (full1 !== 1'b1) begin n_fail++;
      $display("FAIL fpp_count: got full1=%b want 1", full1); end
    ready_out = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if ({validout, dataout, selector} !== {1'b1, exp_tail[i], 1'b1}) begin n_fail++;
        $display("FAIL fpp_drain[%0d]: got %b want %b", i, {validout, dataout, selector}, {1'b1, exp_tail[i], 1'b1}); end
    end
    tick();
    n_tests++; if ({validout, err_ovf} !== 2'b01) begin n_fail++;
      $display("FAIL fpp_end: got valid/err=%b want 01", {validout, err_ovf}); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_stall();
    test_reset_midflight();
    test_full_push_pop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
